// File: rtl/output_accum_mem.sv
// Output tile memory: DEPTH words of LANES signed lanes, NUM_CH overwrite/accumulate channels
// through a two-edge pipeline, plus scan write/read and self-clear. Build macro: OUTMEM_SAT_EN.
module output_accum_mem #(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = 8,
  parameter  int DEPTH  = 256,
  parameter  int LANES  = 32,
  parameter  int LANE_W = 16,
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        scan_addr,
  input  logic [DATA_W-1:0]        scan_in,
  output logic [DATA_W-1:0]        scan_out,
  output logic                     scan_valid_out,
  input  logic [NUM_CH-1:0]        ch_valid_in,
  input  logic [NUM_CH-1:0]        ch_accum_in,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_in,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
  output logic [NUM_CH-1:0]        ch_valid_out,
  output logic [NUM_CH*ADDR_W-1:0] ch_addr_out,
  output logic [NUM_CH*DATA_W-1:0] ch_data_out,
  output logic                     clear_done,
  output logic                     addr_err
);

  typedef enum logic [1:0] {
    MODE_SCAN_WR = 2'b00,
    MODE_RUN     = 2'b01,
    MODE_CLEAR   = 2'b10,
    MODE_SCAN_RD = 2'b11
  } mode_e;

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  function automatic logic signed [LANE_W-1:0] f_lane_add(
    input logic signed [LANE_W-1:0] a,
    input logic signed [LANE_W-1:0] b
  );
    logic signed [LANE_W:0] s;
    s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
`ifdef OUTMEM_SAT_EN
    if (s[LANE_W] != s[LANE_W-1])
      return s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
`endif
    return s[LANE_W-1:0];
  endfunction

  // Lanes are added independently: no carry crosses a lane boundary.
  function automatic logic [DATA_W-1:0] f_word_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*LANE_W +: LANE_W] = f_lane_add(a[l*LANE_W +: LANE_W], b[l*LANE_W +: LANE_W]);
    return r;
  endfunction

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [NUM_CH-1:0]        r_vld_p1;
  logic [NUM_CH-1:0]        r_acc_p1;
  logic [ADDR_W-1:0]        r_addr_p1 [NUM_CH];
  logic [DATA_W-1:0]        r_data_p1 [NUM_CH];
  logic [NUM_CH-1:0]        r_vld_p2;
  logic [NUM_CH*ADDR_W-1:0] r_addr_p2;
  logic [NUM_CH*DATA_W-1:0] r_data_p2;
  logic [DATA_W-1:0]        r_scan_out;
  logic                     r_scan_vld;
  logic [ADDR_W-1:0]        r_clr_cnt;
  logic                     r_clr_done;
  logic                     r_addr_err;

  logic [NUM_CH-1:0]        w_req_ok;
  logic [NUM_CH-1:0]        w_req_bad;
  logic [DATA_W-1:0]        w_res [NUM_CH];
  logic                     w_run;
  logic                     w_scan_mode;
  logic                     w_scan_ok;
  logic                     w_stall;
  logic                     w_clr_wr;

  assign w_run       = (mode == MODE_RUN);
  assign w_scan_mode = (mode == MODE_SCAN_WR) || (mode == MODE_SCAN_RD);
  assign w_scan_ok   = ({1'b0, scan_addr} < DEPTH_L);
  assign w_stall     = |r_vld_p1;
  assign w_clr_wr    = (mode == MODE_CLEAR) && !r_clr_done && !w_stall;

  always_comb begin
    w_req_ok  = '0;
    w_req_bad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_run && ch_valid_in[c]) begin
        if ({1'b0, ch_addr_in[c*ADDR_W +: ADDR_W]} < DEPTH_L) w_req_ok[c]  = 1'b1;
        else                                                  w_req_bad[c] = 1'b1;
      end
    end
  end

  // ---- stage 1 -> stage 2: read-modify-merge; same-address channels fold in channel order
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_res[c] = '0;
      if (r_vld_p1[c]) begin
        w_res[c] = r_mem[r_addr_p1[c][IDX_W-1:0]];
        for (int j = 0; j < NUM_CH; j++) begin
          if (r_vld_p1[j] && (r_addr_p1[j] == r_addr_p1[c]))
            w_res[c] = r_acc_p1[j] ? f_word_add(w_res[c], r_data_p1[j]) : r_data_p1[j];
        end
      end
    end
  end

  // Pipeline write-back wins; a colliding scan or clear write simply repeats next edge.
  always_ff @(posedge clk) begin
    if (w_stall) begin
      for (int c = 0; c < NUM_CH; c++)
        if (r_vld_p1[c]) r_mem[r_addr_p1[c][IDX_W-1:0]] <= w_res[c];
    end else if ((mode == MODE_SCAN_WR) && w_scan_ok) begin
      r_mem[scan_addr[IDX_W-1:0]] <= scan_in;
    end else if (w_clr_wr) begin
      r_mem[r_clr_cnt[IDX_W-1:0]] <= '0;
    end
  end

  // ---- input -> stage 1
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      r_acc_p1[c]  <= ch_accum_in[c];
      r_addr_p1[c] <= ch_addr_in[c*ADDR_W +: ADDR_W];
      r_data_p1[c] <= ch_data_in[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= '0;
      r_vld_p2   <= '0;
      r_addr_p2  <= '0;
      r_data_p2  <= '0;
      r_scan_out <= '0;
      r_scan_vld <= 1'b0;
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_vld_p1 <= w_req_ok;
      // ---- stage 2 -> outputs
      r_vld_p2 <= r_vld_p1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_vld_p1[c]) begin
          r_addr_p2[c*ADDR_W +: ADDR_W] <= r_addr_p1[c];
          r_data_p2[c*DATA_W +: DATA_W] <= w_res[c];
        end
      end

      if ((|w_req_bad) || (w_scan_mode && !w_scan_ok)) r_addr_err <= 1'b1;

      if (mode == MODE_SCAN_RD) begin
        r_scan_vld <= 1'b1;
        r_scan_out <= w_scan_ok ? r_mem[scan_addr[IDX_W-1:0]] : '0;
      end else begin
        r_scan_vld <= 1'b0;
      end

      if (mode != MODE_CLEAR) begin
        r_clr_cnt  <= '0;
        r_clr_done <= 1'b0;
      end else if (w_clr_wr) begin
        if (r_clr_cnt == CLR_LAST) r_clr_done <= 1'b1;
        else                       r_clr_cnt  <= r_clr_cnt + 1'b1;
      end
    end
  end

  assign ch_valid_out   = r_vld_p2;
  assign ch_addr_out    = r_addr_p2;
  assign ch_data_out    = r_data_p2;
  assign scan_out       = r_scan_out;
  assign scan_valid_out = r_scan_vld;
  assign clear_done     = r_clr_done;
  assign addr_err       = r_addr_err;

endmodule

// File: tb/tb_output_accum_mem.sv
// Directed bench for output_accum_mem: clear, overwrite/accumulate, same-address merge,
// lane wrap/saturation, out-of-range drop and asynchronous reset.
module tb_output_accum_mem;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 256;
  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int DATA_W = LANES * LANE_W;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [1:0]               mode;
  logic [ADDR_W-1:0]        scan_addr;
  logic [DATA_W-1:0]        scan_in;
  logic [DATA_W-1:0]        scan_out;
  logic                     scan_valid_out;
  logic [NUM_CH-1:0]        ch_valid_in;
  logic [NUM_CH-1:0]        ch_accum_in;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_in;
  logic [NUM_CH*DATA_W-1:0] ch_data_in;
  logic [NUM_CH-1:0]        ch_valid_out;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_out;
  logic [NUM_CH*DATA_W-1:0] ch_data_out;
  logic                     clear_done;
  logic                     addr_err;

  int n_cmp = 0;
  int n_err = 0;

  output_accum_mem #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LANES(LANES), .LANE_W(LANE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .scan_addr(scan_addr), .scan_in(scan_in), .scan_out(scan_out),
    .scan_valid_out(scan_valid_out),
    .ch_valid_in(ch_valid_in), .ch_accum_in(ch_accum_in),
    .ch_addr_in(ch_addr_in), .ch_data_in(ch_data_in),
    .ch_valid_out(ch_valid_out), .ch_addr_out(ch_addr_out), .ch_data_out(ch_data_out),
    .clear_done(clear_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rep(input logic [LANE_W-1:0] v);
    return {LANES{v}};
  endfunction

  task automatic req(input logic [1:0] v, input logic [1:0] acc,
                     input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                     input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    ch_valid_in = v;
    ch_accum_in = acc;
    ch_addr_in  = {a1, a0};
    ch_data_in  = {d1, d0};
  endtask

  task automatic scan_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mode = 2'b00; scan_addr = a; scan_in = d;
    tick();
    mode = 2'b01;
  endtask

  task automatic scan_check(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    mode = 2'b11; scan_addr = a;
    tick();
    chk({tag, "_vld"}, DATA_W'(scan_valid_out), DATA_W'(1));
    chk(tag, scan_out, exp);
    mode = 2'b01;
  endtask

  logic [DATA_W-1:0] sat_base, sat_add, sat_exp;

  initial begin
    rst_n = 1'b0; mode = 2'b01; scan_addr = '0; scan_in = '0;
    req(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (3) tick();
    chk("rst_ch_valid", DATA_W'(ch_valid_out), '0);
    chk("rst_ch_data0", ch_data_out[DATA_W-1:0], '0);
    chk("rst_flags", DATA_W'({scan_valid_out, clear_done, addr_err}), '0);
    rst_n = 1'b1;
    tick();

    // Test 1: full clear sweep
    mode = 2'b10;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      tick();
      if (i == DEPTH - 1) chk("clr_done_early", DATA_W'(clear_done), '0);
      if (i == DEPTH)     chk("clr_done_set", DATA_W'(clear_done), DATA_W'(1));
    end
    scan_check("clr_rd_00", 9'h000, '0);
    chk("clr_done_leave", DATA_W'(clear_done), '0);
    scan_check("clr_rd_ff", 9'h0FF, '0);

    // Test 2: overwrite then back-to-back accumulate, same address
    req(2'b01, 2'b00, 9'h005, '0, rep(16'h0003), '0);
    tick();
    req(2'b01, 2'b01, 9'h005, '0, rep(16'h0004), '0);
    tick();
    chk("ow_valid", DATA_W'(ch_valid_out), DATA_W'(2'b01));
    chk("ow_addr", DATA_W'(ch_addr_out[ADDR_W-1:0]), DATA_W'(9'h005));
    chk("ow_data", ch_data_out[DATA_W-1:0], rep(16'h0003));
    req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    chk("acc_data", ch_data_out[DATA_W-1:0], rep(16'h0007));
    tick();
    chk("idle_valid", DATA_W'(ch_valid_out), '0);
    scan_check("acc_rd", 9'h005, rep(16'h0007));

    // Test 3: two channels accumulate into one address
    scan_write(9'h00A, rep(16'h0010));
    req(2'b11, 2'b11, 9'h00A, 9'h00A, rep(16'h0001), rep(16'h0002));
    tick();
    req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    chk("merge_valid", DATA_W'(ch_valid_out), DATA_W'(2'b11));
    chk("merge_d0", ch_data_out[DATA_W-1:0], rep(16'h0013));
    chk("merge_d1", ch_data_out[2*DATA_W-1:DATA_W], rep(16'h0013));
    scan_check("merge_rd", 9'h00A, rep(16'h0013));

    // Test 4: ch1 overwrite after ch0 accumulate wins
    scan_write(9'h00B, rep(16'h0100));
    req(2'b11, 2'b01, 9'h00B, 9'h00B, rep(16'h0005), rep(16'h0020));
    tick();
    req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    chk("ow_win_d0", ch_data_out[DATA_W-1:0], rep(16'h0020));
    chk("ow_win_d1", ch_data_out[2*DATA_W-1:DATA_W], rep(16'h0020));
    scan_check("ow_win_rd", 9'h00B, rep(16'h0020));

    // Distinct addresses in the same cycle stay independent
    req(2'b11, 2'b00, 9'h010, 9'h011, rep(16'h0011), rep(16'h0022));
    tick();
    req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    chk("split_a1", DATA_W'(ch_addr_out[2*ADDR_W-1:ADDR_W]), DATA_W'(9'h011));
    chk("split_d0", ch_data_out[DATA_W-1:0], rep(16'h0011));
    chk("split_d1", ch_data_out[2*DATA_W-1:DATA_W], rep(16'h0022));
    scan_check("split_rd", 9'h010, rep(16'h0011));

    // Test 5: lane overflow, no inter-lane carry
    sat_base = {16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF};
    sat_add  = {16'hFFFF, 16'h0001, 16'h0001, 16'h0001};
`ifdef OUTMEM_SAT_EN
    sat_exp  = {16'h8000, 16'h0002, 16'h0000, 16'h7FFF};
`else
    sat_exp  = {16'h7FFF, 16'h0002, 16'h0000, 16'h8000};
`endif
    scan_write(9'h020, sat_base);
    req(2'b10, 2'b10, '0, 9'h020, '0, sat_add);
    tick();
    req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    chk("ovf_data", ch_data_out[2*DATA_W-1:DATA_W], sat_exp);
    scan_check("ovf_rd", 9'h020, sat_exp);

    // Test 6: out-of-range request dropped
    chk("err_clear", DATA_W'(addr_err), '0);
    req(2'b01, 2'b00, 9'h1F0, '0, rep(16'h0055), '0);
    tick();
    req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    chk("oor_valid", DATA_W'(ch_valid_out), '0);
    chk("oor_err", DATA_W'(addr_err), DATA_W'(1));
    scan_check("oor_alias_rd", 9'h0F0, '0);

    // Asynchronous reset with both pipeline stages occupied
    scan_check("pre_rst_rd", 9'h005, rep(16'h0007));
    req(2'b01, 2'b00, 9'h030, '0, rep(16'h0009), '0);
    tick();
    req(2'b01, 2'b01, 9'h030, '0, rep(16'h0001), '0);
    tick();
    chk("pre_rst_valid", DATA_W'(ch_valid_out), DATA_W'(2'b01));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", DATA_W'(ch_valid_out), '0);
    chk("arst_addr", DATA_W'(ch_addr_out), '0);
    chk("arst_data", ch_data_out[DATA_W-1:0], '0);
    chk("arst_scan", scan_out, '0);
    chk("arst_flags", DATA_W'({scan_valid_out, clear_done, addr_err}), '0);
    req(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", DATA_W'(ch_valid_out), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
